// File: rtl/adc_capture_sequencer_pkg.sv
// Shared types and constants for the ADC capture sequencer: FSM states,
// UART frame header and the sample/word packing helpers.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAP_WAIT,
        CAP_CONV,
        CAP_WR,
        RD_CMD,
        RD_WAIT,
        TX
    } state_t;

    localparam logic [7:0] FRAME_HDR        = 8'hAA;
    localparam int         SAMPLES_PER_WORD = 2;
    localparam int         ADDR_W           = 23;

    function automatic logic [31:0] pack_word(input logic [11:0] even, input logic [11:0] odd);
        return {4'h0, odd, 4'h0, even};
    endfunction

    // Six-byte UART frame per word: header + even sample, header + odd sample.
    function automatic logic [7:0] frame_byte(input logic [31:0] word, input logic [2:0] idx);
        case (idx)
            3'd0, 3'd3: return FRAME_HDR;
            3'd1:       return {4'h0, word[11:8]};
            3'd2:       return word[7:0];
            3'd4:       return {4'h0, word[27:24]};
            default:    return word[23:16];
        endcase
    endfunction

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// Bundle of the ADC handshake, SDRAM command/return port and UART transmit
// signals; master is the sequencer side, slave the peripheral side.
interface adc_capture_sequencer_if;
    import capture_pkg::*;

    logic              adc_start;
    logic              adc_busy;
    logic              adc_new_data;
    logic [11:0]       adc_data;

    logic              cmd_ready;
    logic              cmd_enable;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_address;
    logic [31:0]       cmd_data_in;

    logic [31:0]       data_out;
    logic              data_out_ready;

    logic [7:0]        tx_byte;
    logic              tx_en;
    logic              tx_ready;

    modport master (
        output adc_start, cmd_enable, cmd_wr, cmd_address, cmd_data_in, tx_byte, tx_en,
        input  adc_busy, adc_new_data, adc_data, cmd_ready, data_out, data_out_ready, tx_ready
    );

    modport slave (
        input  adc_start, cmd_enable, cmd_wr, cmd_address, cmd_data_in, tx_byte, tx_en,
        output adc_busy, adc_new_data, adc_data, cmd_ready, data_out, data_out_ready, tx_ready
    );

endinterface

// File: rtl/adc_capture_sequencer_tick_gen.sv
// Free-running sample-rate divider: one-cycle tick every DIV cycles while en,
// restarting from zero each time en rises.
module sample_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else if (cnt == CW'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/adc_capture_sequencer.sv
// Captures MCP3201 samples into SDRAM (two per word) and streams them back
// out as 3-byte UART frames per sample.
module adc_capture_sequencer
    import capture_pkg::*;
#(
    parameter int SAMPLE_DIV  = 100000,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    dump,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    adc_capture_sequencer_if.master bus
);
    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [11:0]       even_r;
    logic [31:0]       word_r;
    logic [0:0]        sample_cnt;
    logic [2:0]        byte_cnt;
    logic              tick;
    logic              cap_active;
    logic              last_word;

    assign cap_active = (state == CAP_WAIT) || (state == CAP_CONV) || (state == CAP_WR);
    assign busy       = (state != IDLE);
    // Widened by one bit so DEPTH_WORDS = 2^23 terminates instead of wrapping.
    assign last_word  = (({1'b0, idx} + 24'd1) == 24'(DEPTH_WORDS));

    sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (cap_active),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            even_r          <= '0;
            word_r          <= '0;
            sample_cnt      <= '0;
            byte_cnt        <= '0;
            done            <= 1'b0;
            overrun         <= 1'b0;
            bus.adc_start   <= 1'b0;
            bus.cmd_enable  <= 1'b0;
            bus.cmd_wr      <= 1'b0;
            bus.cmd_address <= '0;
            bus.cmd_data_in <= '0;
            bus.tx_byte     <= '0;
            bus.tx_en       <= 1'b0;
        end else begin
            done <= 1'b0;
            // The divider never stalls; a tick landing mid-handshake is lost.
            if (tick && (state == CAP_CONV || state == CAP_WR))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (arm) begin
                        state      <= CAP_WAIT;
                        idx        <= '0;
                        sample_cnt <= '0;
                        overrun    <= 1'b0;
                    end else if (dump) begin
                        state           <= RD_CMD;
                        idx             <= '0;
                        bus.cmd_enable  <= 1'b1;
                        bus.cmd_wr      <= 1'b0;
                        bus.cmd_address <= '0;
                    end
                end

                CAP_WAIT: begin
                    if (tick) begin
                        state         <= CAP_CONV;
                        bus.adc_start <= 1'b1;
                    end
                end

                CAP_CONV: begin
                    if (bus.adc_new_data) begin
                        bus.adc_start <= 1'b0;
                        if (sample_cnt == 1'(SAMPLES_PER_WORD - 1)) begin
                            bus.cmd_data_in <= pack_word(even_r, bus.adc_data);
                            bus.cmd_enable  <= 1'b1;
                            bus.cmd_wr      <= 1'b1;
                            bus.cmd_address <= idx;
                            sample_cnt      <= '0;
                            state           <= CAP_WR;
                        end else begin
                            even_r     <= bus.adc_data;
                            sample_cnt <= sample_cnt + 1'b1;
                            state      <= CAP_WAIT;
                        end
                    end
                end

                CAP_WR: begin
                    if (bus.cmd_enable && bus.cmd_ready) begin
                        bus.cmd_enable <= 1'b0;
                        idx            <= idx + 1'b1;
                        if (last_word) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= CAP_WAIT;
                        end
                    end
                end

                RD_CMD: begin
                    if (bus.cmd_enable && bus.cmd_ready) begin
                        bus.cmd_enable <= 1'b0;
                        state          <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (bus.data_out_ready) begin
                        word_r   <= bus.data_out;
                        byte_cnt <= '0;
                        state    <= TX;
                    end
                end

                TX: begin
                    // The cycle tx_en is high doubles as the gap before re-sampling tx_ready.
                    if (bus.tx_en) begin
                        bus.tx_en <= 1'b0;
                        if (byte_cnt == 3'd5) begin
                            idx <= idx + 1'b1;
                            if (last_word) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state           <= RD_CMD;
                                bus.cmd_enable  <= 1'b1;
                                bus.cmd_wr      <= 1'b0;
                                bus.cmd_address <= idx + 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (bus.tx_ready) begin
                        bus.tx_en   <= 1'b1;
                        bus.tx_byte <= frame_byte(word_r, byte_cnt);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed/randomized bench for adc_capture_sequencer with ADC, SDRAM and UART
// peripheral models and a sample-list reference model.
module tb_adc_capture_sequencer;
    localparam int DIV   = 64;
    localparam int DEPTH = 4;

    typedef struct {
        bit          wr;
        int          addr;
        logic [31:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arm = 1'b0;
    logic dump = 1'b0;
    logic busy, done, overrun;

    adc_capture_sequencer_if bus();

    adc_capture_sequencer #(.SAMPLE_DIV(DIV), .DEPTH_WORDS(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .dump    (dump),
        .busy    (busy),
        .done    (done),
        .overrun (overrun),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral model state
    int          adc_delay = 0;
    int          adc_mode = 0;
    int          adc_n = 0;
    logic [11:0] samples[$];
    logic [11:0] ref_s[$];
    cmd_t        cmds[$];
    logic [31:0] mem[int];
    logic [7:0]  rxq[$];
    int          starts[$];
    bit          rd_pend = 0;
    int          rd_addr = 0;
    int          rd_lat = 0;
    bit          ready_rand = 0;
    bit          force_low = 0;
    bit          tx_rand = 0;
    logic        mdl_rdy = 1'b0;
    logic        stray_rdy = 1'b0;
    logic [31:0] mdl_data = '0;
    logic [31:0] stray_data = '0;
    int          done_cnt = 0;
    int          tx_b2b = 0;
    int          tx_ungated = 0;
    bit          prev_tx_en = 0;
    bit          prev_txr = 0;
    bit          prev_start = 0;

    assign bus.data_out_ready = mdl_rdy | stray_rdy;
    assign bus.data_out       = stray_rdy ? stray_data : mdl_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ADC: answers each adc_start after adc_delay cycles with the next sample.
    initial begin
        logic [11:0] v;
        bus.adc_new_data = 1'b0;
        bus.adc_data     = '0;
        bus.adc_busy     = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.adc_start && !rst) begin
                if (adc_delay > 0) begin
                    repeat (adc_delay) @(posedge clk);
                    #1;
                end
                v = (adc_mode == 0) ? 12'(12'h100 + adc_n) : 12'($urandom);
                adc_n++;
                samples.push_back(v);
                bus.adc_data     = v;
                bus.adc_new_data = 1'b1;
                @(posedge clk); #1;
                bus.adc_new_data = 1'b0;
            end
        end
    end

    // SDRAM ready/read-return and UART ready drivers.
    initial begin
        bus.cmd_ready = 1'b0;
        bus.tx_ready  = 1'b0;
        forever begin
            @(posedge clk); #1;
            mdl_rdy = 1'b0;
            if (rd_pend) begin
                if (rd_lat == 0) begin
                    mdl_data = mem.exists(rd_addr) ? mem[rd_addr] : 32'h0;
                    mdl_rdy  = 1'b1;
                    rd_pend  = 0;
                end else begin
                    rd_lat--;
                end
            end
            bus.cmd_ready = force_low ? 1'b0 : (ready_rand ? ($urandom_range(3) != 0) : 1'b1);
            bus.tx_ready  = tx_rand ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Mid-cycle monitor: command acceptance, UART bytes, done and ADC start times.
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) done_cnt++;
                if (bus.tx_en) begin
                    rxq.push_back(bus.tx_byte);
                    if (prev_tx_en) tx_b2b++;
                    if (!prev_txr) tx_ungated++;
                end
                if (bus.adc_start && !prev_start) starts.push_back(cyc);
                if (bus.cmd_enable && bus.cmd_ready) begin
                    c.wr   = bus.cmd_wr;
                    c.addr = int'(bus.cmd_address);
                    c.data = bus.cmd_data_in;
                    cmds.push_back(c);
                    if (c.wr) mem[c.addr] = c.data;
                    else begin
                        rd_pend = 1;
                        rd_addr = c.addr;
                        rd_lat  = $urandom_range(0, 6);
                    end
                end
            end
            prev_tx_en = !rst && bus.tx_en;
            prev_txr   = bus.tx_ready;
            prev_start = !rst && bus.adc_start;
        end
    end

    task automatic clear_logs();
        samples.delete();
        cmds.delete();
        starts.delete();
        rxq.delete();
        adc_n      = 0;
        tx_b2b     = 0;
        tx_ungated = 0;
    endtask

    task automatic pulse(input logic a, input logic d);
        @(posedge clk); #1;
        arm  = a;
        dump = d;
        @(posedge clk); #1;
        arm  = 1'b0;
        dump = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 20000), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    endtask

    // Expected writes: word k holds sample 2k in the low half, 2k+1 in the high half.
    task automatic check_capture(input string tag);
        int nw, nr;
        logic [31:0] e;
        nw = 0;
        nr = 0;
        chk({tag, "_samples"}, samples.size(), 2 * DEPTH);
        ref_s = samples;
        foreach (cmds[i]) begin
            if (cmds[i].wr) begin
                if (2 * nw + 1 < samples.size())
                    e = (32'(samples[2*nw+1]) << 16) | 32'(samples[2*nw]);
                else
                    e = 32'hDEAD_BEEF;
                chk($sformatf("%s_addr%0d", tag, nw), cmds[i].addr, nw);
                chk($sformatf("%s_data%0d", tag, nw), cmds[i].data, e);
                nw++;
            end else begin
                nr++;
            end
        end
        chk({tag, "_nwrites"}, nw, DEPTH);
        chk({tag, "_nreads"}, nr, 0);
    endtask

    // Expected UART stream: per sample AA, high nibble, low byte, in capture order.
    task automatic check_dump(input string tag);
        logic [11:0] s;
        logic [7:0]  e;
        chk({tag, "_nbytes"}, rxq.size(), 6 * DEPTH);
        for (int i = 0; i < rxq.size() && i < 6 * DEPTH; i++) begin
            s = ref_s[2 * (i / 6) + (i % 6) / 3];
            case (i % 3)
                0:       e = 8'hAA;
                1:       e = 8'(s >> 8);
                default: e = 8'(s & 12'hFF);
            endcase
            chk($sformatf("%s_byte%0d", tag, i), rxq[i], e);
        end
        foreach (cmds[i])
            chk($sformatf("%s_rd%0d", tag, i), cmds[i].wr ? 32'hFFFF_FFFF : 32'(cmds[i].addr), i);
        chk({tag, "_nreads"}, cmds.size(), DEPTH);
        chk({tag, "_tx_b2b"}, tx_b2b, 0);
        chk({tag, "_tx_ungated"}, tx_ungated, 0);
    endtask

    // ADC start spacing: exactly DIV, or a non-zero multiple of DIV when ticks are dropped.
    task automatic check_period(input string tag, input bit exact);
        int bad, d;
        bad = 0;
        chk({tag, "_nstarts"}, starts.size(), 2 * DEPTH);
        for (int i = 1; i < starts.size(); i++) begin
            d = starts[i] - starts[i-1];
            if (exact ? (d != DIV) : (d == 0 || d % DIV != 0)) bad++;
        end
        chk({tag, "_spacing"}, bad, 0);
    endtask

    initial begin
        int d0, n, bad;
        logic [31:0] w;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_adc_start", bus.adc_start, 0);
        chk("rst_cmd_enable", bus.cmd_enable, 0);
        chk("rst_cmd_wr", bus.cmd_wr, 0);
        chk("rst_cmd_address", bus.cmd_address, 0);
        chk("rst_cmd_data_in", bus.cmd_data_in, 0);
        chk("rst_tx_en", bus.tx_en, 0);
        chk("rst_tx_byte", bus.tx_byte, 0);
        rst = 1'b0;

        // Capture 4 words of 12'h100+n
        clear_logs();
        adc_mode = 0; adc_delay = 0; ready_rand = 0; tx_rand = 0;
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        chk("cap4_busy", busy, 1);
        wait_done("cap4", d0);
        check_capture("cap4");
        if (cmds.size() >= 2) begin
            chk("cap4_word0", cmds[0].data, 32'h01010100);
            chk("cap4_word1", cmds[1].data, 32'h01030102);
        end
        chk("cap4_overrun", overrun, 0);
        check_period("cap4_period", 1'b1);

        // Dump those 4 words with a stalling UART
        cmds.delete(); rxq.delete(); tx_b2b = 0; tx_ungated = 0;
        tx_rand = 1;
        d0 = done_cnt;
        pulse(1'b0, 1'b1);
        wait_done("dump4", d0);
        check_dump("dump4");
        if (rxq.size() >= 6)
            chk("dump4_first6", {rxq[0], rxq[1], rxq[2], rxq[3]}, 32'hAA0100AA);

        // Random samples, random write backpressure, then dump
        clear_logs();
        adc_mode = 1; adc_delay = $urandom_range(0, 8); ready_rand = 1;
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        wait_done("rnd_cap", d0);
        check_capture("rnd_cap");
        check_period("rnd_period", 1'b1);
        chk("rnd_overrun", overrun, 0);
        cmds.delete(); rxq.delete(); tx_b2b = 0; tx_ungated = 0;
        d0 = done_cnt;
        pulse(1'b0, 1'b1);
        wait_done("rnd_dump", d0);
        check_dump("rnd_dump");

        // Slow ADC drops ticks
        clear_logs();
        adc_delay = 100; ready_rand = 0;
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        wait_done("ovr", d0);
        chk("ovr_overrun", overrun, 1);
        check_period("ovr_period", 1'b0);
        check_capture("ovr");
        clear_logs();
        adc_delay = 0;
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        chk("ovr_cleared_by_arm", overrun, 0);
        wait_done("ovr_next", d0);
        check_capture("ovr_next");
        chk("ovr_next_overrun", overrun, 0);

        // Write backpressure: hold cmd_ready low for 50 cycles
        clear_logs();
        force_low = 1;
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        n = 0;
        while (!bus.cmd_enable && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait", 32'(n < 1000), 32'd1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            w = (samples.size() >= 2) ? ((32'(samples[1]) << 16) | 32'(samples[0])) : 32'hDEAD_BEEF;
            if (!(bus.cmd_enable && bus.cmd_address == 0 && bus.cmd_data_in == w)) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_none_accepted", cmds.size(), 0);
        force_low = 0;
        wait_done("bp", d0);
        check_capture("bp");

        // arm+dump together starts a capture; dump while busy is ignored
        clear_logs();
        d0 = done_cnt;
        pulse(1'b1, 1'b1);
        chk("coll_busy", busy, 1);
        repeat (30) @(posedge clk);
        pulse(1'b0, 1'b1);
        wait_done("coll", d0);
        check_capture("coll");
        chk("coll_no_uart", rxq.size(), 0);

        // Stray read return in IDLE
        @(posedge clk); #1;
        stray_data = 32'h0ABC_0DEF;
        stray_rdy  = 1'b1;
        @(posedge clk); #1;
        stray_rdy  = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("stray_no_uart", rxq.size(), 0);
        chk("stray_idle", busy, 0);

        // Reset during the third byte of a dump
        cmds.delete(); rxq.delete();
        pulse(1'b0, 1'b1);
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(bus.tx_en && rxq.size() == 2) && n < 2000);
        chk("rstd_wait", 32'(n < 2000), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstd_tx_en", bus.tx_en, 0);
        chk("rstd_cmd_enable", bus.cmd_enable, 0);
        chk("rstd_adc_start", bus.adc_start, 0);
        chk("rstd_busy", busy, 0);
        chk("rstd_done", done, 0);
        rst = 1'b0;
        cmds.delete(); rxq.delete(); tx_b2b = 0; tx_ungated = 0;
        d0 = done_cnt;
        pulse(1'b0, 1'b1);
        wait_done("rstd_dump", d0);
        check_dump("rstd_dump");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
